// File: rtl/timer_counter_if.sv
// Bridge-side bus bundle for one timer_counter window: address/data/write strobe in,
// combinational read data, registered interrupt and FSM state out.
interface timer_counter_if;
  // Bus protocol: no handshake; a write completes on the rising edge where we=1,
  // and dout is valid in the same cycle addr is presented (zero-latency read).
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic [1:0]  state_dbg;

  modport master (
    output addr,
    output we,
    output din,
    input  dout,
    input  irq,
    input  state_dbg
  );

  modport slave (
    input  addr,
    input  we,
    input  din,
    output dout,
    output irq,
    output state_dbg
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and (optional) auto-reload modes.
// Auto-reload (MODE=01) is compiled in only when TC_AUTO_RELOAD_EN is defined.
module timer_counter (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;       // {IM, MODE[1:0], EN}
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        auto_reload;
  logic        clr_en;
  logic        set_flag;
  logic        unused_addr_bits;

  assign sel              = bus.addr[3:2];
  assign wr_ctrl          = bus.we && (sel == REG_CTRL);
  assign wr_preset        = bus.we && (sel == REG_PRESET);
  assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

`ifdef TC_AUTO_RELOAD_EN
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
`else
  assign auto_reload = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    irq_flag_d = irq_flag_q;
    clr_en     = 1'b0;
    set_flag   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET of 0 or 1 lands here on the first counting cycle; never wraps.
          count_d  = 32'd0;
          set_flag = 1'b1;
          state_d  = S_INT;
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (!auto_reload) clr_en = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A CTRL write in the same cycle overrides the FSM clearing EN.
    if (wr_ctrl)     ctrl_d = bus.din[3:0];
    else if (clr_en) ctrl_d = {ctrl_q[3:1], 1'b0};

    if (wr_preset) preset_d = bus.din;

    if (set_flag)                               irq_flag_d = 1'b1;
    else if (wr_ctrl || wr_preset)              irq_flag_d = 1'b0;
    else if ((state_q == S_INT) && auto_reload) irq_flag_d = 1'b0;

    irq_d = irq_flag_q & ctrl_q[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    case (sel)
      REG_CTRL:   bus.dout = {28'd0, ctrl_q};
      REG_PRESET: bus.dout = preset_q;
      REG_COUNT:  bus.dout = count_q;
      default:    bus.dout = 32'd0;
    endcase
  end

  assign bus.irq       = irq_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a cycle model of the timer checked against the DUT
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_timer_counter;

`ifdef TC_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  timer_counter_if bus_if();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_q[$];
  int high_cnt = 0;
  logic prev_irq = 1'b0;

  // Timer model: phase, registers, sticky event flag, registered irq.
  int          m_phase = PH_IDLE;
  logic [3:0]  m_ctrl = 4'd0;
  logic [31:0] m_preset = 32'd0;
  logic [31:0] m_count = 32'd0;
  bit          m_flag = 1'b0;
  bit          m_irq = 1'b0;
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one rising edge, given the bus inputs seen at that edge.
  task automatic model_step(input bit rst, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit          running, reload, hit_ctrl, hit_pre, expired;
    int          nxt;
    logic [3:0]  c_nxt;
    logic [31:0] n_nxt;
    if (rst) begin
      m_phase = PH_IDLE; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
      m_flag = 1'b0; m_irq = 1'b0;
      return;
    end
    running  = m_ctrl[0];
    reload   = AUTO && (m_ctrl[2:1] == 2'b01);
    hit_ctrl = w && (a[3:2] == 2'd0);
    hit_pre  = w && (a[3:2] == 2'd1);
    expired  = 1'b0;
    nxt      = m_phase;
    c_nxt    = m_ctrl;
    n_nxt    = m_count;
    if (m_phase == PH_IDLE) begin
      if (running) nxt = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      n_nxt = m_preset;
      nxt   = PH_CNT;
    end else if (m_phase == PH_CNT) begin
      if (!running) nxt = PH_IDLE;
      else if (m_count <= 32'd1) begin
        n_nxt = 32'd0; expired = 1'b1; nxt = PH_INT;
      end else n_nxt = m_count - 32'd1;
    end else begin
      nxt = PH_IDLE;
      if (!reload) c_nxt[0] = 1'b0;
    end
    if (hit_ctrl) c_nxt = d[3:0];
    m_irq = m_flag && m_ctrl[3];
    if (expired) m_flag = 1'b1;
    else if (hit_ctrl || hit_pre) m_flag = 1'b0;
    else if (m_phase == PH_INT && reload) m_flag = 1'b0;
    if (hit_pre) m_preset = d;
    m_ctrl  = c_nxt;
    m_count = n_nxt;
    m_phase = nxt;
  endtask

  // One bus cycle: drive inputs, cross the rising edge, update the model, settle.
  task automatic cycle(input bit w, input logic [31:0] a, input logic [31:0] d);
    bus_if.we = w; bus_if.addr = a; bus_if.din = d;
    @(posedge clk);
    model_step(reset, w, a, d);
    m_valid = 1'b1;
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) cycle(1'b0, a, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus_if.we = 1'b0; bus_if.addr = a;
    #1;
    v = bus_if.dout;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (m_valid) begin
      chk("dout_vs_model", bus_if.dout, model_read(bus_if.addr));
      chk("irq_vs_model", {31'd0, bus_if.irq}, {31'd0, m_irq});
      chk("state_vs_model", {30'd0, bus_if.state_dbg}, 32'(m_phase));
      if (bus_if.irq && !prev_irq) rise_q.push_back(cyc);
      if (bus_if.irq) high_cnt++;
      prev_irq = bus_if.irq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bus_if.we = 1'b0; bus_if.addr = 32'd0; bus_if.din = 32'd0;

    // Reset with writes asserted: nothing must stick.
    reset = 1'b1;
    wr(32'h7F04, 32'h1234);
    wr(32'h7F00, 32'hF);
    wr(32'h7F00, 32'hF);
    reset = 1'b0;
    idle(1, 32'h7F00);
    rd(32'h7F00, v); chk("reset_ctrl", v, 32'h0);
    rd(32'h7F04, v); chk("reset_preset", v, 32'h0);
    rd(32'h7F08, v); chk("reset_count", v, 32'h0);
    chk("reset_irq", {31'd0, bus_if.irq}, 32'd0);

    // One-shot, PRESET=5: count 5..0, sticky irq, EN cleared.
    wr(32'h7F04, 32'd5);
    wr(32'h7F00, 32'h9);
    idle(1, 32'h7F08);
    for (int i = 0; i < 6; i++) begin
      idle(1, 32'h7F08);
      rd(32'h7F08, v); chk("oneshot_count_seq", v, 32'(5 - i));
    end
    idle(1, 32'h7F08);
    chk("oneshot_irq_high", {31'd0, bus_if.irq}, 32'd1);
    idle(3, 32'h7F00);
    chk("oneshot_irq_sticky", {31'd0, bus_if.irq}, 32'd1);
    rd(32'h7F00, v); chk("oneshot_ctrl_en_cleared", v, 32'h8);
    wr(32'h7F00, 32'h8);
    idle(1, 32'h7F00);
    chk("oneshot_irq_cleared", {31'd0, bus_if.irq}, 32'd0);

    // MODE=01, PRESET=3.
    wr(32'h7F04, 32'd3);
    rise_q.delete(); high_cnt = 0;
    wr(32'h7F00, 32'hB);
    idle(30, 32'h7F08);
`ifdef TC_AUTO_RELOAD_EN
    chk("reload_pulse_count_ge3", {31'd0, rise_q.size() >= 3}, 32'd1);
    for (int i = 1; i < rise_q.size(); i++)
      chk("reload_pulse_gap", 32'(rise_q[i] - rise_q[i-1]), 32'd6);
    chk("reload_pulse_width", 32'(high_cnt), 32'(rise_q.size()));
`else
    chk("noreload_one_pulse", 32'(rise_q.size()), 32'd1);
    chk("noreload_irq_sticky", {31'd0, bus_if.irq}, 32'd1);
    rd(32'h7F00, v); chk("noreload_ctrl", v, 32'hA);
`endif
    wr(32'h7F00, 32'h0);
    idle(3, 32'h7F08);
    chk("mode01_stopped_irq", {31'd0, bus_if.irq}, 32'd0);

    // Clear EN while COUNT=7: freezes at 6, then re-enable reloads PRESET.
    wr(32'h7F04, 32'd10);
    wr(32'h7F00, 32'h1);
    idle(5, 32'h7F08);
    rd(32'h7F08, v); chk("freeze_count_before", v, 32'd7);
    wr(32'h7F00, 32'h0);
    idle(3, 32'h7F08);
    rd(32'h7F08, v); chk("freeze_count_held", v, 32'd6);
    chk("freeze_state_idle", {30'd0, bus_if.state_dbg}, 32'd0);
    chk("freeze_no_irq", {31'd0, bus_if.irq}, 32'd0);
    wr(32'h7F00, 32'h1);
    idle(2, 32'h7F08);
    rd(32'h7F08, v); chk("freeze_reload", v, 32'd10);
    wr(32'h7F00, 32'h0);
    idle(2, 32'h7F08);

    // Writes to COUNT and to the reserved offset change nothing.
    wr(32'h7F08, 32'hFFFF);
    wr(32'h7F0C, 32'hFFFF);
    rd(32'h7F08, v); chk("ro_count", v, 32'd9);
    rd(32'h7F00, v); chk("ro_ctrl", v, 32'h0);
    rd(32'h7F04, v); chk("ro_preset", v, 32'd10);
    rd(32'h7F0C, v); chk("reserved_reads_zero", v, 32'h0);

    // PRESET=0 terminates on the first counting cycle.
    wr(32'h7F04, 32'd0);
    wr(32'h7F00, 32'h9);
    idle(4, 32'h7F08);
    chk("preset0_irq", {31'd0, bus_if.irq}, 32'd1);
    rd(32'h7F08, v); chk("preset0_count", v, 32'd0);
    wr(32'h7F00, 32'h0);
    idle(2, 32'h7F08);

    // CTRL write lands on the INT cycle: the write keeps EN set.
    wr(32'h7F04, 32'd2);
    wr(32'h7F00, 32'h9);
    idle(4, 32'h7F08);
    chk("race_state_int", {30'd0, bus_if.state_dbg}, 32'd3);
    wr(32'h7F00, 32'h9);
    rd(32'h7F00, v); chk("race_ctrl_write_wins", v, 32'h9);
    idle(10, 32'h7F08);
    rd(32'h7F00, v); chk("race_second_run_ctrl", v, 32'h8);
    chk("race_second_run_irq", {31'd0, bus_if.irq}, 32'd1);
    wr(32'h7F00, 32'h0);
    idle(2, 32'h7F08);

    // Reset one cycle before terminal count: no interrupt ever.
    wr(32'h7F04, 32'd4);
    wr(32'h7F00, 32'h9);
    idle(5, 32'h7F08);
    rise_q.delete();
    reset = 1'b1;
    idle(1, 32'h7F08);
    reset = 1'b0;
    idle(5, 32'h7F08);
    chk("abort_no_irq_pulse", 32'(rise_q.size()), 32'd0);
    rd(32'h7F08, v); chk("abort_count", v, 32'd0);
    rd(32'h7F00, v); chk("abort_ctrl", v, 32'h0);
    chk("abort_irq", {31'd0, bus_if.irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
